// File: rtl/reg_fifo_pkg.sv
// Shared types and helpers for the configurable register / delay / FIFO unit.
package reg_fifo_pkg;

  typedef enum logic [1:0] {
    MODE_REG   = 2'd0,
    MODE_DELAY = 2'd1,
    MODE_FIFO  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_fifo_ctrl.sv
// FIFO bookkeeping: read/write pointers, occupancy and the valid/ready handshake.
module reg_fifo_ctrl
  import reg_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned CNT_W = cnt_w(DEPTH),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_act,
  input  logic             i_flush,
  input  logic             i_in_valid,
  input  logic             i_out_ready,
  output logic             o_in_ready_c,
  output logic             o_out_valid_c,
  output logic             o_push_c,
  output logic [AW-1:0]    o_wr_ptr,
  output logic [AW-1:0]    o_rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Full blocks writes even when a pop happens in the same cycle (no bypass).
  assign o_in_ready_c  = i_enable && i_act && !w_full;
  assign o_out_valid_c = i_enable && i_act && !w_empty;

  assign w_push = i_in_valid && o_in_ready_c;
  assign w_pop  = o_out_valid_c && i_out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  assign o_push_c = w_push;
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_empty  = w_empty;

endmodule

// File: rtl/reg_fifo_unit.sv
// Configurable CGRA buffer: one-stage register, 1..DEPTH delay line, or FWFT FIFO.
// DELAY and FIFO modes share the same DEPTH x WIDTH storage registers.
module reg_fifo_unit
  import reg_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic             tide_en,
  input  logic             tide_rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  mode_e            w_mode;
  logic             w_act;
  logic             w_flush;
  logic             w_is_fifo;
  logic [CNT_W-1:0] w_n;
  logic [AW-1:0]    w_tap;

  logic             w_in_ready_c;
  logic             w_out_valid_c;
  logic             w_push;
  logic [AW-1:0]    w_wr_ptr;
  logic [AW-1:0]    w_rd_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_dv;
  logic [WIDTH-1:0] r_reg_data;
  logic             r_reg_valid;

  assign w_mode    = mode_e'(cfg_mode);
  assign w_act     = !tide_en || en;
  assign w_flush   = tide_rst && clr;
  assign w_is_fifo = (w_mode == MODE_FIFO);

  // Effective delay: 0 behaves as 1, anything past DEPTH saturates.
  always_comb begin
    w_n = cfg_delay;
    if (cfg_delay == '0) begin
      w_n = CNT_W'(1);
    end else if (cfg_delay > CNT_W'(DEPTH)) begin
      w_n = CNT_W'(DEPTH);
    end
  end

  assign w_tap = AW'(w_n - CNT_W'(1));

  reg_fifo_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (w_is_fifo),
    .i_act         (w_act),
    .i_flush       (w_flush),
    .i_in_valid    (in_valid),
    .i_out_ready   (out_ready),
    .o_in_ready_c  (w_in_ready_c),
    .o_out_valid_c (w_out_valid_c),
    .o_push_c      (w_push),
    .o_wr_ptr      (w_wr_ptr),
    .o_rd_ptr      (w_rd_ptr),
    .o_count       (w_count),
    .o_empty       (w_empty)
  );

  // Storage is never reset; DELAY shifts through it, FIFO writes at wr_ptr.
  always_ff @(posedge clk) begin
    if (!w_flush) begin
      if (w_mode == MODE_DELAY && w_act) begin
        r_mem[0] <= in_data;
        for (int k = 1; k < DEPTH; k++) begin
          r_mem[k] <= r_mem[k-1];
        end
      end else if (w_push) begin
        r_mem[w_wr_ptr] <= in_data;
      end
    end
  end

  // REG stage and DELAY valid chain: the only state cleared by reset/flush here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_data  <= '0;
      r_reg_valid <= 1'b0;
      r_dv        <= '0;
    end else if (w_flush) begin
      r_reg_data  <= '0;
      r_reg_valid <= 1'b0;
      r_dv        <= '0;
    end else if (w_act) begin
      if (w_mode == MODE_REG) begin
        r_reg_data  <= in_data;
        r_reg_valid <= in_valid;
      end
      if (w_mode == MODE_DELAY) begin
        r_dv <= {r_dv[DEPTH-2:0], in_valid};
      end
    end
  end

  // Invalid DELAY stages and an empty FIFO present zero data.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    count     = '0;
    case (w_mode)
      MODE_REG: begin
        in_ready  = 1'b1;
        out_valid = r_reg_valid;
        out_data  = r_reg_data;
      end
      MODE_DELAY: begin
        in_ready  = 1'b1;
        out_valid = r_dv[w_tap];
        out_data  = r_dv[w_tap] ? r_mem[w_tap] : '0;
      end
      MODE_FIFO: begin
        in_ready  = w_in_ready_c;
        out_valid = w_out_valid_c;
        out_data  = w_empty ? '0 : r_mem[w_rd_ptr];
        count     = w_count;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        count     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_fifo_unit.sv
// Scoreboard bench for reg_fifo_unit: randomized traffic in every mode against a
// latency/occupancy reference model, plus the directed scenarios from the test plan.
module tb_reg_fifo_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       cfg_mode = 2'd0;
  logic [CNT_W-1:0] cfg_delay = CNT_W'(1);
  logic             tide_en = 1'b0;
  logic             tide_rst = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mdl_e;
  int unsigned act_total = 0;
  int unsigned epoch = 0;
  int unsigned occ = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  reg_fifo_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_mode  (cfg_mode),
    .cfg_delay (cfg_delay),
    .tide_en   (tide_en),
    .tide_rst  (tide_rst),
    .en        (en),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic int unsigned delay_n();
    if (cfg_delay == '0) return 1;
    if (int'(cfg_delay) > int'(DEPTH)) return DEPTH;
    return int'(cfg_delay);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Reference model: each active input word is due N active edges later (REG: N=1);
  // the FIFO is an occupancy count plus an in-order list of accepted words.
  always @(posedge clk or posedge rst) begin : model
    int unsigned t;
    bit          do_push;
    bit          do_pop;
    if (rst) begin
      exp_q.delete();
      occ = 0;
      epoch++;
    end else if (tide_rst && clr) begin
      exp_q.delete();
      occ = 0;
      epoch++;
    end else if (!tide_en || en) begin
      t = act_total;
      act_total = t + 1;
      if (cfg_mode == 2'd0 || cfg_mode == 2'd1) begin
        if (in_valid) begin
          mdl_e.data = in_data;
          mdl_e.due  = t + ((cfg_mode == 2'd0) ? 1 : delay_n());
          exp_q.push_back(mdl_e);
        end
      end else if (cfg_mode == 2'd2) begin
        do_push = in_valid && (occ < DEPTH);
        do_pop  = out_ready && (occ > 0);
        if (do_push) begin
          mdl_e.data = in_data;
          mdl_e.due  = t + 1;
          exp_q.push_back(mdl_e);
        end
        occ = occ + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      end
    end
  end

  // Monitor: compares DUT outputs away from the rising edge and pops the scoreboard.
  initial begin : monitor
    bit          last_v;
    logic [31:0] last_d;
    int unsigned seen_total;
    int unsigned seen_epoch;
    bit          act_n;
    exp_t        f;
    last_v = 1'b0;
    last_d = '0;
    seen_total = 0;
    seen_epoch = 0;
    forever begin
      @(negedge clk or posedge rst);
      act_n = !tide_en || en;
      if (rst) begin
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready),
            (cfg_mode == 2'd2) ? 32'(act_n) : ((cfg_mode == 2'd3) ? 32'd0 : 32'd1));
        last_v = 1'b0;
        seen_total = act_total;
        seen_epoch = epoch;
      end else if (cfg_mode == 2'd0 || cfg_mode == 2'd1) begin
        if (epoch != seen_epoch) begin
          seen_epoch = epoch;
          last_v = 1'b0;
        end
        if (act_total != seen_total) begin
          seen_total = act_total;
          last_v = 1'b0;
          if (exp_q.size() > 0 && exp_q[0].due == act_total) begin
            f = exp_q.pop_front();
            last_v = 1'b1;
            last_d = f.data;
          end
        end
        chk("pipe_out_valid", 32'(out_valid), 32'(last_v));
        if (last_v) chk("pipe_out_data", out_data, last_d);
        chk("pipe_in_ready", 32'(in_ready), 32'd1);
        chk("pipe_count", 32'(count), 32'd0);
      end else if (cfg_mode == 2'd2) begin
        chk("fifo_in_ready", 32'(in_ready), 32'(act_n && occ < DEPTH));
        chk("fifo_out_valid", 32'(out_valid), 32'(act_n && occ > 0));
        chk("fifo_count", 32'(count), occ);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("fifo_pop_unexpected", 32'd1, 32'd0);
          end else begin
            f = exp_q.pop_front();
            chk("fifo_out_data", out_data, f.data);
          end
        end
      end else begin
        chk("rsvd_in_ready", 32'(in_ready), 32'd0);
        chk("rsvd_out_valid", 32'(out_valid), 32'd0);
        chk("rsvd_out_data", out_data, 32'd0);
        chk("rsvd_count", 32'(count), 32'd0);
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic e,
                     input logic c, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    en        = e;
    clr       = c;
    out_ready = rdy;
  endtask

  task automatic reset_to(input logic [1:0] m, input int unsigned dly,
                          input logic te, input logic tr);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    cfg_mode  = m;
    cfg_delay = CNT_W'(dly);
    tide_en   = te;
    tide_rst  = tr;
    in_valid  = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset asserted between edges while traffic is flowing.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_run(input int n, input int p_en, input int p_v,
                          input int p_rdy, input int p_clr);
    for (int i = 0; i < n; i++) begin
      cyc(int'($urandom_range(99)) < p_v, $urandom, int'($urandom_range(99)) < p_en,
          int'($urandom_range(99)) < p_clr, int'($urandom_range(99)) < p_rdy);
    end
  endtask

  initial begin : driver
    int unsigned dl[6];
    dl = '{0, 1, 2, 4, 5, 7};

    // REG mode
    reset_to(2'd0, 1, 1'b0, 1'b1);
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rand_run(40, 50, 60, 50, 5);
    mid_reset();
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    rand_run(20, 50, 60, 50, 5);
    reset_to(2'd0, 1, 1'b1, 1'b1);
    rand_run(40, 60, 60, 50, 5);

    // DELAY mode, N = 3, stall with en = 0
    reset_to(2'd1, 3, 1'b1, 1'b1);
    cyc(1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    rand_run(60, 70, 60, 50, 4);
    mid_reset();
    rand_run(20, 70, 60, 50, 0);
    foreach (dl[i]) begin
      reset_to(2'd1, dl[i], 1'b1, 1'b1);
      rand_run(40, 70, 60, 50, 5);
    end
    reset_to(2'd1, 2, 1'b1, 1'b0);
    rand_run(30, 70, 60, 50, 20);

    // FIFO: fill past full, then drain with pointer wrap
    reset_to(2'd2, 1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(32'hA0 + i), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hA4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    // simultaneous push/pop at count 2, then at full
    cyc(1'b1, 32'hB0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hB1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(32'hB2 + i), 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hC1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hC2, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'hC3, 1'b1, 1'b0, 1'b1);
    // flush at count 3
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'hD0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    // same flush pulse ignored when tide_rst = 0
    reset_to(2'd2, 1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'hE0 + i), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    // randomized FIFO traffic
    reset_to(2'd2, 1, 1'b1, 1'b1);
    rand_run(300, 80, 60, 50, 3);
    mid_reset();
    cyc(1'b1, 32'hF00D_0001, 1'b1, 1'b0, 1'b1);
    rand_run(100, 80, 70, 40, 2);
    reset_to(2'd2, 1, 1'b0, 1'b1);
    rand_run(200, 50, 50, 60, 3);

    // reserved mode
    reset_to(2'd3, 1, 1'b1, 1'b1);
    rand_run(10, 80, 80, 80, 0);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
